// File: rtl/tempsense_sar_ctrl_pkg.sv
// Shared definitions for the SAR temperature-sensor sequencer:
// state encodings (also decoded by the debug mux) and small helpers.
package tempsense_sar_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRECHARGE  = 3'd1;
    localparam logic [STATE_W-1:0] ST_TRANSITION = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEASURE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_EVALUATE   = 3'd4;
    localparam logic [STATE_W-1:0] ST_ACCUM      = 3'd5;
    localparam logic [STATE_W-1:0] ST_WAIT       = 3'd6;

    // Busy means a conversion is in flight; IDLE and WAIT are the rest states.
    function automatic logic f_is_busy(input logic [STATE_W-1:0] st);
        return (st != ST_IDLE) && (st != ST_WAIT);
    endfunction

    // Counter width that can hold the value n (at least one bit).
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/tempsense_sar_ctrl_avg.sv
// Averaging back end: sums the SAR result of each conversion, counts
// conversions and publishes the truncated mean with a one-cycle valid.
module tempsense_avg
    import tempsense_sar_ctrl_pkg::*;
#(
    parameter int N_VDAC   = 6,
    parameter int LOG2_AVG = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic [N_VDAC-1:0] i_sample,
    output logic              o_last,
    output logic [N_VDAC-1:0] o_result,
    output logic              o_valid
);

    localparam int ACC_W   = N_VDAC + LOG2_AVG;
    localparam int CNT_W   = LOG2_AVG + 1;
    localparam int NUM_AVG = 1 << LOG2_AVG;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_sum;

    // Running sum including the sample being added this cycle; the final
    // average is taken from it so the last add and the publish share an edge.
    assign w_sum  = r_acc + ACC_W'(i_sample);
    assign o_last = (r_cnt == CNT_W'(NUM_AVG - 1));

    // Accumulate, count conversions, publish the mean after the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            o_result <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (i_add) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
                if (o_last) begin
                    o_result <= N_VDAC'(w_sum >> LOG2_AVG);
                    o_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tempsense_sar_ctrl.sv
// SAR sequencer for the tempsense delay macro: per bit it precharges,
// releases the line with the DAC at VMIN, then applies the trial code and
// samples whether the macro signalled a delay. Averaged results are
// produced single-shot or continuously with an idle interval.
module tempsense_sar_ctrl
    import tempsense_sar_ctrl_pkg::*;
#(
    parameter int N_VDAC      = 6,
    parameter int LOG2_AVG    = 2,
    parameter int MEAS_CYCLES = 1,
    parameter int INTERVAL    = 16384
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_continuous,
    input  logic               i_tempdelay,
    output logic [N_VDAC-1:0]  o_dac_data,
    output logic               o_dac_en,
    output logic               o_precharge_n,
    output logic [N_VDAC-1:0]  o_result,
    output logic               o_valid,
    output logic               o_busy,
    output logic [STATE_W-1:0] o_state
);

    localparam int BIT_W  = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
    localparam int MEAS_W = f_cnt_w(MEAS_CYCLES);
    localparam int INT_W  = f_cnt_w(INTERVAL);

    localparam logic [N_VDAC-1:0] VMAX     = {N_VDAC{1'b1}};
    localparam logic [N_VDAC-1:0] VMIN     = {N_VDAC{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_TOP  = BIT_W'(N_VDAC - 1);
    localparam logic [MEAS_W-1:0] MEAS_END = MEAS_W'(MEAS_CYCLES - 1);
    localparam logic [INT_W-1:0]  INT_END  = INT_W'(INTERVAL);

    logic [STATE_W-1:0] r_state;
    logic [N_VDAC-1:0]  r_sar;
    logic [BIT_W-1:0]   r_bit;
    logic [MEAS_W-1:0]  r_meas;
    logic [INT_W-1:0]   r_ivl;

    logic [N_VDAC-1:0]  w_trial;
    logic               w_clear;
    logic               w_add;
    logic               w_last;

    assign w_trial = r_sar | (N_VDAC'(1) << r_bit);

    // A new averaged measurement begins on the edge leaving IDLE or WAIT.
    // WAIT holds for INTERVAL+1 cycles so the exit edge mirrors the IDLE
    // edge that samples i_start.
    assign w_clear = ((r_state == ST_IDLE) && (i_start || i_continuous)) ||
                     ((r_state == ST_WAIT) && i_continuous && (r_ivl == INT_END));
    assign w_add   = (r_state == ST_ACCUM);

    // Sequencer: state, SAR register, bit index and the two timers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sar   <= '0;
            r_bit   <= BIT_TOP;
            r_meas  <= '0;
            r_ivl   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ivl <= '0;
                    if (i_start || i_continuous) begin
                        r_state <= ST_PRECHARGE;
                        r_sar   <= '0;
                        r_bit   <= BIT_TOP;
                    end
                end
                ST_PRECHARGE: r_state <= ST_TRANSITION;
                ST_TRANSITION: begin
                    r_state <= ST_MEASURE;
                    r_meas  <= '0;
                end
                ST_MEASURE: begin
                    if (r_meas == MEAS_END) r_state <= ST_EVALUATE;
                    else                    r_meas  <= r_meas + MEAS_W'(1);
                end
                ST_EVALUATE: begin
                    // No delay means the trial code is still below the sensor
                    // threshold, so keep the bit.
                    if (!i_tempdelay) r_sar <= w_trial;
                    if (r_bit == '0) begin
                        r_state <= ST_ACCUM;
                    end else begin
                        r_bit   <= r_bit - BIT_W'(1);
                        r_state <= ST_PRECHARGE;
                    end
                end
                ST_ACCUM: begin
                    r_sar <= '0;
                    r_bit <= BIT_TOP;
                    r_ivl <= '0;
                    if (!w_last)           r_state <= ST_PRECHARGE;
                    else if (i_continuous) r_state <= ST_WAIT;
                    else                   r_state <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (!i_continuous) begin
                        r_state <= ST_IDLE;
                    end else if (r_ivl == INT_END) begin
                        r_state <= ST_PRECHARGE;
                        r_ivl   <= '0;
                    end else begin
                        r_ivl <= r_ivl + INT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Macro drive decoded from the registered state.
    always_comb begin
        o_dac_en      = 1'b0;
        o_dac_data    = VMAX;
        o_precharge_n = 1'b0;
        case (r_state)
            ST_PRECHARGE, ST_ACCUM: begin
                o_dac_en = 1'b1;
            end
            ST_TRANSITION: begin
                o_dac_en      = 1'b1;
                o_dac_data    = VMIN;
                o_precharge_n = 1'b1;
            end
            ST_MEASURE, ST_EVALUATE: begin
                o_dac_en      = 1'b1;
                o_dac_data    = w_trial;
                o_precharge_n = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_busy  = f_is_busy(r_state);
    assign o_state = r_state;

    tempsense_avg #(
        .N_VDAC   (N_VDAC),
        .LOG2_AVG (LOG2_AVG)
    ) u_avg (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_add    (w_add),
        .i_sample (r_sar),
        .o_last   (w_last),
        .o_result (o_result),
        .o_valid  (o_valid)
    );

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Directed bench for tempsense_sar_ctrl; the sensor is modelled as
// delay = (dac_data > thr) with thr set per scenario.
module tb_tempsense_sar_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_continuous = 1'b0;
    logic       i_tempdelay;
    logic [5:0] o_dac_data;
    logic       o_dac_en;
    logic       o_precharge_n;
    logic [5:0] o_result;
    logic       o_valid;
    logic       o_busy;
    logic [2:0] o_state;

    int thr = 37;
    int n_pass = 0;
    int n_total = 0;
    int idle_bad = 0;

    always #5 clk = ~clk;

    always_comb i_tempdelay = (int'(o_dac_data) > thr);

    tempsense_sar_ctrl #(
        .N_VDAC      (6),
        .LOG2_AVG    (2),
        .MEAS_CYCLES (1),
        .INTERVAL    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_continuous  (i_continuous),
        .i_tempdelay   (i_tempdelay),
        .o_dac_data    (o_dac_data),
        .o_dac_en      (o_dac_en),
        .o_precharge_n (o_precharge_n),
        .o_result      (o_result),
        .o_valid       (o_valid),
        .o_busy        (o_busy),
        .o_state       (o_state)
    );

    // Count edges until o_valid is seen (-1 if bound expires); also watches
    // that the macro is disabled and busy is low whenever at rest.
    task automatic wait_valid(input int bound, output int cyc);
        cyc = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk); #1;
            if ((o_state == 3'd0 || o_state == 3'd6) && (o_dac_en !== 1'b0 || o_busy !== 1'b0))
                idle_bad++;
            if (o_valid === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    // Raise start (or continuous) so the next edge samples it; returns #1 after that edge.
    task automatic kick(input bit cont);
        @(negedge clk);
        if (cont) i_continuous = 1'b1;
        else      i_start = 1'b1;
        @(posedge clk); #1;
        if (!cont) i_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (o_state !== 3'd0) $display("FAIL rst_state got %0d exp 0", o_state); else n_pass++;
        n_total++; if (o_result !== 6'd0) $display("FAIL rst_result got %0d exp 0", o_result); else n_pass++;
        n_total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", o_valid); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", o_busy); else n_pass++;
        n_total++; if (o_dac_en !== 1'b0) $display("FAIL rst_dac_en got %b exp 0", o_dac_en); else n_pass++;
        n_total++; if (o_dac_data !== 6'd63) $display("FAIL rst_dac_data got %0d exp 63", o_dac_data); else n_pass++;
        n_total++; if (o_precharge_n !== 1'b0) $display("FAIL rst_prech got %b exp 0", o_precharge_n); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single(input int t, input logic [5:0] exp_res);
        int c;
        thr = t;
        kick(1'b0);
        n_total++; if (o_busy !== 1'b1 || o_dac_en !== 1'b1 || o_precharge_n !== 1'b0 || o_dac_data !== 6'd63)
            $display("FAIL single%0d_precharge got busy=%b en=%b pn=%b dac=%0d exp 1 1 0 63",
                     t, o_busy, o_dac_en, o_precharge_n, o_dac_data);
        else n_pass++;
        wait_valid(300, c);
        n_total++; if (c !== 100) $display("FAIL single%0d_latency got %0d exp 100", t, c); else n_pass++;
        n_total++; if (o_result !== exp_res) $display("FAIL single%0d_result got %0d exp %0d", t, o_result, exp_res); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_state !== 3'd0 || o_dac_en !== 1'b0)
            $display("FAIL single%0d_after got valid=%b busy=%b state=%0d en=%b exp 0 0 0 0",
                     t, o_valid, o_busy, o_state, o_dac_en);
        else n_pass++;
    endtask

    task automatic test_avg();
        int tab[4];
        int c;
        tab[0] = 36; tab[1] = 37; tab[2] = 38; tab[3] = 40;
        thr = tab[0];
        kick(1'b0);
        for (int k = 1; k < 4; k++) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (o_state == 3'd5) break;
            end
            thr = tab[k];
            @(negedge clk);
        end
        wait_valid(300, c);
        n_total++; if (c < 1) $display("FAIL avg_valid got %0d exp >0", c); else n_pass++;
        n_total++; if (o_result !== 6'd37) $display("FAIL avg_result got %0d exp 37", o_result); else n_pass++;
    endtask

    task automatic test_continuous();
        int c;
        thr = 37;
        kick(1'b1);
        wait_valid(300, c);
        n_total++; if (c !== 100) $display("FAIL cont_first got %0d exp 100", c); else n_pass++;
        n_total++; if (o_state !== 3'd6 || o_busy !== 1'b0) $display("FAIL cont_wait got state=%0d busy=%b exp 6 0", o_state, o_busy); else n_pass++;
        wait_valid(300, c);
        n_total++; if (c !== 109) $display("FAIL cont_period got %0d exp 109", c); else n_pass++;
        n_total++; if (o_result !== 6'd37) $display("FAIL cont_result got %0d exp 37", o_result); else n_pass++;
        @(negedge clk);
        i_continuous = 1'b0;
        @(posedge clk); #1;
        n_total++; if (o_state !== 3'd0) $display("FAIL cont_drop got %0d exp 0", o_state); else n_pass++;
        wait_valid(250, c);
        n_total++; if (c !== -1) $display("FAIL cont_no_more got %0d exp -1", c); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c;
        thr = 37;
        kick(1'b0);
        repeat (49) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_total++; if (o_state !== 3'd0 || o_busy !== 1'b0 || o_valid !== 1'b0)
            $display("FAIL mid_ctrl got state=%0d busy=%b valid=%b exp 0 0 0", o_state, o_busy, o_valid);
        else n_pass++;
        n_total++; if (o_result !== 6'd0) $display("FAIL mid_result got %0d exp 0", o_result); else n_pass++;
        n_total++; if (o_dac_en !== 1'b0 || o_dac_data !== 6'd63 || o_precharge_n !== 1'b0)
            $display("FAIL mid_drive got en=%b dac=%0d pn=%b exp 0 63 0", o_dac_en, o_dac_data, o_precharge_n);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        wait_valid(200, c);
        n_total++; if (c !== -1) $display("FAIL mid_no_valid got %0d exp -1", c); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c;
        thr = 37;
        kick(1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_valid(200, c);
        n_total++; if (c !== 69) $display("FAIL busy_start_latency got %0d exp 69", c); else n_pass++;
        n_total++; if (o_result !== 6'd37) $display("FAIL busy_start_result got %0d exp 37", o_result); else n_pass++;
        wait_valid(200, c);
        n_total++; if (c !== -1) $display("FAIL busy_start_single got %0d exp -1", c); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single(37, 6'd37);
        test_single(63, 6'd63);
        test_single(-1, 6'd0);
        test_avg();
        test_continuous();
        test_reset_mid();
        test_back_to_back();
        n_total++; if (idle_bad !== 0) $display("FAIL rest_drive got %0d bad cycles exp 0", idle_bad); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tempsense_sar_ctrl.md
# tempsense_sar_ctrl

Parametrised successor to the single-sweep temperature-sensor sequencer. It drives the `tempsense` delay macro with a successive-approximation (SAR) search instead of a linear DAC ramp, averages 2**LOG2_AVG conversions, and supports single-shot or continuous operation with a programmable idle interval. It sits between the `tempsense` instance and the display/debug logic; its `o_result` feeds `bin2dec`.

## Interface
- `N_VDAC`, 6: DAC resolution in bits; also the result width.
- `LOG2_AVG`, 2: log2 of the number of conversions averaged (0..4).
- `MEAS_CYCLES`, 1: cycles spent in MEASURE per bit trial (>=1).
- `INTERVAL`, 16384: idle cycles between conversions in continuous mode (>=1).
- `clk`  in  1  system clock (~10 kHz).
- `reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  level; sampled in IDLE, starts one averaged measurement.
- `i_continuous`  in  1  level; when high, measurements repeat after INTERVAL.
- `i_tempdelay`  in  1  `o_tempdelay` from `tempsense`.
- `o_dac_data`  out  N_VDAC  to `i_dac_data`.
- `o_dac_en`  out  1  to `i_dac_en`.
- `o_precharge_n`  out  1  to `i_precharge_n`.
- `o_result`  out  N_VDAC  last averaged result.
- `o_valid`  out  1  one-cycle pulse when `o_result` updates.
- `o_busy`  out  1  high in every state except IDLE and WAIT.
- `o_state`  out  3  state encoding, for the debug mux.

## Operation
- States: IDLE(0), PRECHARGE(1), TRANSITION(2), MEASURE(3), EVALUATE(4), ACCUM(5), WAIT(6).
- Outputs per state (registered state, combinational decode):
  - IDLE/WAIT: dac_en=0, dac_data=VMAX, precharge_n=0.
  - PRECHARGE: dac_en=1, dac_data=VMAX, precharge_n=0.
  - TRANSITION: dac_en=1, dac_data=VMIN, precharge_n=1.
  - MEASURE/EVALUATE: dac_en=1, dac_data=trial, precharge_n=1.
  - ACCUM: dac_en=1, dac_data=VMAX, precharge_n=0.
- SAR: bit index b runs from N_VDAC-1 down to 0; trial = sar | (1<<b). In EVALUATE, sample `i_tempdelay`. If 0, sar <= trial; otherwise sar unchanged. Then go to PRECHARGE for b-1; after b=0, go to ACCUM.
- ACCUM: acc <= acc + sar (acc width N_VDAC+LOG2_AVG, cleared on start); sar cleared; conv count incremented. If count < 2**LOG2_AVG, go to PRECHARGE; else o_result <= acc >> LOG2_AVG (truncating), o_valid pulses, then go to WAIT if i_continuous else IDLE.
- WAIT: an interval counter counts INTERVAL cycles, then a new measurement starts (acc cleared). If i_continuous drops during WAIT, go to IDLE on the next edge.
- IDLE: leave on i_start | i_continuous.

## Timing
- Reset values: state=IDLE, o_result=0, o_valid=0, o_busy=0, acc/sar/counters=0, o_dac_en=0, o_dac_data=VMAX, o_precharge_n=0.
- Bit trial = 3+MEAS_CYCLES cycles. Conversion = N_VDAC*(3+MEAS_CYCLES)+1 cycles.
- Latency from the edge sampling i_start in IDLE to o_valid high = 2**LOG2_AVG*(N_VDAC*(3+MEAS_CYCLES)+1) cycles. Defaults: 100.
- i_tempdelay is sampled only at the clock edge ending EVALUATE. It is not synchronised; the analog timing is set by MEAS_CYCLES.
- i_start while busy is ignored. i_start during WAIT is ignored.
- Reset mid-measurement aborts the measurement. o_result returns to 0 and no o_valid is issued.
- Boundaries: i_tempdelay always 0 gives o_result=VMAX. Always 1 gives 0. The acc sum never overflows by construction.
- Continuous period = latency + INTERVAL + 1 cycles (the WAIT exit edge starts PRECHARGE).

## Structure
- Shared include `tempsense_defs.vh`: state encodings and the VMAX/VMIN macros. The debug mux and the top level use them as well.
- One natural sub-module, `tempsense_avg`: accumulator, conversion counter and result register, with clear/add/done ports.
- The FSM, SAR register and interval counter stay in the parent.

## Test plan
- Model tempsense as delay = (dac_data > 37); single shot with defaults -> o_valid at cycle 100 after start, o_result=37, o_busy low afterwards.
- Threshold 63 (never delays) -> result 63. Threshold -1 (always delays) -> result 0.
- LOG2_AVG=2, thresholds per conversion 36,37,38,40 -> (151>>2)=37.
- i_continuous=1, INTERVAL=8 -> o_valid pulses every 109 cycles. Drop i_continuous in WAIT -> IDLE with no further pulse.
- Assert reset at cycle 50 of a measurement -> all outputs at reset values next cycle, no o_valid.
- Pulse i_start while busy -> ignored, exactly one o_valid. Check dac_en=0 in IDLE/WAIT throughout.
